uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz (informational).
REQ-002 Parameter TIMEOUT_CYCLES, default 500_000, inter-byte timeout in clk cycles (10 ms at 50 MHz).
REQ-003 Parameter SYNC_BYTE, default 8'hAA, frame start marker.
REQ-004 clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 rx_data  input  8  received byte from UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data valid in the same cycle.
REQ-008 cmd_ack  input  1  consumer accepts the pending command.
REQ-009 cmd_code  output  8  command byte of the last good frame.
REQ-010 cmd_arg  output  8  argument byte of the last good frame.
REQ-011 cmd_valid  output  1  high while a good frame is pending, until acknowledged.
REQ-012 busy  output  1  high when the FSM is not in S_IDLE.
REQ-013 err_chk  output  1  one-cycle pulse on checksum mismatch.
REQ-014 err_overrun  output  1  one-cycle pulse when a good frame is dropped because one is already pending.
REQ-015 err_timeout  output  1  one-cycle pulse on mid-frame timeout.

Function
REQ-016 Frame format SHALL be 4 bytes: SYNC_BYTE, CMD, ARG, CHK, with CHK == CMD ^ ARG.
REQ-017 FSM states SHALL be S_IDLE, S_CMD, S_ARG, S_CHK; any other encoding SHALL go to S_IDLE next cycle.
REQ-018 S_IDLE: rx_valid with rx_data == SYNC_BYTE -> S_CMD; any other byte SHALL be ignored without error.
REQ-019 S_CMD: rx_valid -> latch CMD, go to S_ARG; S_ARG: rx_valid -> latch ARG, go to S_CHK.
REQ-020 Bytes equal to SYNC_BYTE in S_CMD/S_ARG/S_CHK SHALL be treated as data; no resync.
REQ-021 S_CHK: rx_valid -> S_IDLE; on match the frame is good, on mismatch err_chk pulses the next cycle.
REQ-022 Good frame with cmd_valid low SHALL load cmd_code/cmd_arg and set cmd_valid on the next clk edge (1-cycle latency from the CHK strobe).
REQ-023 Good frame with cmd_valid high and cmd_ack low SHALL be dropped; outputs unchanged; err_overrun pulses.
REQ-024 Good frame and cmd_ack in the same cycle SHALL load the new frame; cmd_valid stays high; no err_overrun.
REQ-025 cmd_ack with cmd_valid high and no good frame completing SHALL clear cmd_valid next cycle; cmd_ack with cmd_valid low SHALL be ignored.
REQ-026 cmd_code/cmd_arg SHALL hold stable while cmd_valid is high.
REQ-027 Timeout counter (32-bit) SHALL clear on every rx_valid and whenever in S_IDLE, and increment each cycle in S_CMD/S_ARG/S_CHK.
REQ-028 Counter reaching TIMEOUT_CYCLES-1 without rx_valid SHALL force S_IDLE, discard the partial frame, and pulse err_timeout.
REQ-029 rx_valid in the same cycle as timeout expiry SHALL win: the byte is processed and there is no timeout.
REQ-030 Error pulses SHALL be mutually exclusive per frame and never last longer than one cycle.

Reset
REQ-031 rst high SHALL, at the next clk edge, set state S_IDLE, the counter to 0, cmd_code = 8'h00, cmd_arg = 8'h00, and cmd_valid, busy, err_chk, err_overrun and err_timeout to 0.
REQ-032 rst mid-frame or with a command pending SHALL discard all frame and pending data; there are no error pulses during or on exit from reset.

Configuration
REQ-033 Macro UART_CMD_PARSER_TIMEOUT_EN defined: REQ-027..REQ-029 apply.
REQ-034 Macro undefined: no timeout counter is synthesized; err_timeout is tied to 0; the FSM waits indefinitely mid-frame.

Verification
REQ-035 Bytes AA,12,34,26 -> cmd_valid=1, cmd_code=12, cmd_arg=34 one cycle after the CHK strobe; cmd_ack -> cmd_valid=0.
REQ-036 Bytes AA,12,34,27 -> err_chk single pulse, cmd_valid stays 0, busy=0.
REQ-037 Frame AA,01,02,03 left unacked, then AA,05,06,03 -> err_overrun pulse, cmd_code stays 01; repeating with cmd_ack on the final CHK cycle -> cmd_code=05, cmd_valid=1.
REQ-038 TIMEOUT_CYCLES=100, bytes AA,12 then idle -> err_timeout exactly 100 cycles after the 12 strobe; with the macro undefined -> no pulse, busy stays 1.
REQ-039 Bytes 55,AA,AA,AA,00 -> 55 ignored; frame CMD=AA, ARG=AA, CHK=00 is good.
REQ-040 rst asserted after AA,12 -> busy=0; a subsequent full AA,12,34,26 decodes normally.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Byte-stream framer for 4-byte UART commands (SYNC, CMD, ARG, CMD^ARG) with a single-entry pending slot.
// Optional inter-byte timeout is built only when UART_CMD_PARSER_TIMEOUT_EN is defined.
module uart_cmd_parser #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cmd_ack,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       cmd_valid,
    output logic       busy,
    output logic       err_chk,
    output logic       err_overrun,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_ARG  = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] cmd_lat;
    logic [7:0] arg_lat;
    logic       frame_good;
    logic       frame_bad;
    logic       expire;

    if (TIMEOUT_CYCLES < 2 || CLK_FREQ == 0) begin : g_bad_params
        $error("uart_cmd_parser: TIMEOUT_CYCLES must be >= 2 and CLK_FREQ non-zero");
    end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    // Expiry is flagged on the edge where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 2);

    logic [31:0] tmo_cnt;

    assign expire = (state != S_IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst || rx_valid || state == S_IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= expire;
        end
    end
`else
    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    state_next = S_ARG;
                end
            end
            S_ARG: begin
                if (rx_valid) begin
                    state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    state_next = S_IDLE;
                    if (rx_data == (cmd_lat ^ arg_lat)) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (expire) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_lat     <= '0;
            arg_lat     <= '0;
            cmd_code    <= '0;
            cmd_arg     <= '0;
            cmd_valid   <= 1'b0;
            err_chk     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (state == S_CMD && rx_valid) begin
                cmd_lat <= rx_data;
            end
            if (state == S_ARG && rx_valid) begin
                arg_lat <= rx_data;
            end
            err_chk     <= frame_bad;
            err_overrun <= frame_good && cmd_valid && !cmd_ack;
            // An ack in the completing cycle frees the slot for the new frame.
            if (frame_good && (!cmd_valid || cmd_ack)) begin
                cmd_code  <= cmd_lat;
                cmd_arg   <= arg_lat;
                cmd_valid <= 1'b1;
            end else if (!frame_good && cmd_ack) begin
                cmd_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus randomized traffic against a frame-queue model.
// Expected timeout behaviour follows UART_CMD_PARSER_TIMEOUT_EN as seen by this file.
module tb_uart_cmd_parser;

    localparam int unsigned TMO = 100;
    localparam logic [7:0]  SYNC = 8'hAA;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_ack;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       cmd_valid;
    logic       busy;
    logic       err_chk;
    logic       err_overrun;
    logic       err_timeout;

    uart_cmd_parser #(
        .CLK_FREQ      (50_000_000),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_BYTE     (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_ack    (cmd_ack),
        .cmd_code   (cmd_code),
        .cmd_arg    (cmd_arg),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .err_chk    (err_chk),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: collected frame bytes, pending slot, silent-cycle count.
    logic [7:0]  frame[$];
    int unsigned silent;
    logic [7:0]  e_code, e_arg;
    logic        e_valid, e_chk, e_ovr, e_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic a);
        logic good;
        good  = 1'b0;
        e_chk = 1'b0;
        e_ovr = 1'b0;
        e_tmo = 1'b0;
        if (r) begin
            frame.delete();
            silent  = 0;
            e_code  = 8'h00;
            e_arg   = 8'h00;
            e_valid = 1'b0;
            return;
        end
        if (v) begin
            silent = 0;
            if (frame.size() == 0) begin
                if (d == SYNC) frame.push_back(d);
            end else begin
                frame.push_back(d);
                if (frame.size() == 4) begin
                    if (frame[3] == (frame[1] ^ frame[2])) good = 1'b1;
                    else e_chk = 1'b1;
                    frame.delete();
                end
            end
        end else if (frame.size() != 0 && TMO_EN) begin
            silent++;
            if (silent == TMO - 1) begin
                e_tmo = 1'b1;
                frame.delete();
                silent = 0;
            end
        end
        if (good) begin
            if (!e_valid || a) begin
                e_code  = frame_cmd_hold;
                e_arg   = frame_arg_hold;
                e_valid = 1'b1;
            end else begin
                e_ovr = 1'b1;
            end
        end else if (a) begin
            e_valid = 1'b0;
        end
    endtask

    // CMD/ARG of the frame in flight, captured as bytes arrive (the queue is cleared on completion).
    logic [7:0] frame_cmd_hold, frame_arg_hold;

    task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic a);
        @(negedge clk);
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        cmd_ack  = a;
        @(posedge clk);
        if (!r && v && frame.size() == 1) frame_cmd_hold = d;
        if (!r && v && frame.size() == 2) frame_arg_hold = d;
        model_step(r, v, d, a);
        #1;
        chk("cmd_valid", 32'(cmd_valid), 32'(e_valid));
        chk("cmd_code", 32'(cmd_code), 32'(e_code));
        chk("cmd_arg", 32'(cmd_arg), 32'(e_arg));
        chk("busy", 32'(busy), 32'(frame.size() != 0));
        chk("err_chk", 32'(err_chk), 32'(e_chk));
        chk("err_overrun", 32'(err_overrun), 32'(e_ovr));
        chk("err_timeout", 32'(err_timeout), 32'(e_tmo));
    endtask

    task automatic send(input logic [7:0] d, input logic a);
        cycle(1'b0, 1'b1, d, a);
    endtask

    task automatic idle(input int unsigned n, input logic a);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom), a);
    endtask

    initial begin
        int unsigned lat;
        bit          seen;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cmd_ack = 1'b0;
        frame_cmd_hold = '0; frame_arg_hold = '0;
        silent = 0; e_code = '0; e_arg = '0; e_valid = 1'b0;
        e_chk = 1'b0; e_ovr = 1'b0; e_tmo = 1'b0;

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, SYNC, 1'b1);
        idle(2, 1'b0);

        // Good frame, then acknowledge.
        send(SYNC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h26, 0);
        chk("good_code", 32'(cmd_code), 32'h12);
        chk("good_arg", 32'(cmd_arg), 32'h34);
        chk("good_valid", 32'(cmd_valid), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ack_clears", 32'(cmd_valid), 32'd0);
        idle(2, 1'b1);

        // Checksum error.
        send(SYNC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h27, 0);
        chk("bad_chk_pulse", 32'(err_chk), 32'd1);
        idle(2, 1'b0);

        // Overrun, then replacement with ack on the CHK cycle.
        send(SYNC, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        send(SYNC, 0); send(8'h05, 0); send(8'h06, 0); send(8'h03, 0);
        chk("ovr_pulse", 32'(err_overrun), 32'd1);
        chk("ovr_keep", 32'(cmd_code), 32'h01);
        send(SYNC, 0); send(8'h05, 0); send(8'h06, 0); send(8'h03, 1);
        chk("ack_replace", 32'(cmd_code), 32'h05);
        chk("ack_replace_ovr", 32'(err_overrun), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Junk before sync, SYNC values as data.
        send(8'h55, 0); send(SYNC, 0); send(SYNC, 0); send(SYNC, 0); send(8'h00, 0);
        chk("sync_data_code", 32'(cmd_code), 32'hAA);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-frame and with a pending command.
        send(SYNC, 0); send(8'h12, 0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_busy", 32'(busy), 32'd0);
        send(SYNC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h26, 0);
        cycle(1'b1, 1'b1, SYNC, 1'b0);
        send(SYNC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h26, 0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Timeout latency measured from the CMD strobe (strobe cycle = 0).
        send(SYNC, 0); send(8'h12, 0);
        seen = 1'b0; lat = 0;
        for (int unsigned k = 1; k <= 130; k++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            if (err_timeout && !seen) begin
                seen = 1'b1;
                lat  = k + 1;
            end
        end
        if (TMO_EN) begin
            chk("tmo_latency", lat, TMO);
        end else begin
            chk("tmo_absent", 32'(seen), 32'd0);
            chk("tmo_wait_busy", 32'(busy), 32'd1);
            send(8'h34, 0); send(8'h26, 0);
            chk("tmo_late_frame", 32'(cmd_valid), 32'd1);
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end

        // Byte arriving in the expiry cycle is processed.
        send(SYNC, 0); send(8'h12, 0);
        idle(TMO - 2, 1'b0);
        send(8'h34, 0); send(8'h26, 0);
        chk("tmo_race_valid", 32'(cmd_valid), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized frames with gaps, bad checksums and random acks.
        for (int unsigned f = 0; f < 300; f++) begin
            logic [7:0] b[4];
            b[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : SYNC;
            b[1] = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
            b[2] = 8'($urandom);
            b[3] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (b[1] ^ b[2]);
            for (int unsigned j = 0; j < 4; j++) begin
                int unsigned gap;
                gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 4, TMO + 4)
                                                   : $urandom_range(0, 3);
                for (int unsigned g = 0; g < gap; g++)
                    cycle(1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 2) == 0));
                cycle(($urandom_range(0, 199) == 0), 1'b1, b[j], 1'($urandom_range(0, 2) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
